// File: rtl/cmd_pkg.sv
// Shared types and constants for the command-bus arbiter: FSM encoding,
// soft-reset command pattern and requester grant ids.
package cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_ACK     = 3'd3,
        ST_SOFTRST = 3'd4
    } state_t;

    localparam logic [7:0] SOFTRST_ADDR = 8'h01;
    localparam logic [7:0] SOFTRST_DATA = 8'h02;

    localparam logic GNT_VJTAG  = 1'b0;
    localparam logic GNT_EXPORT = 1'b1;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    function automatic logic is_softrst(input cmd_t c);
        return (c.addr == SOFTRST_ADDR) && (c.data == SOFTRST_DATA);
    endfunction

endpackage

// File: rtl/cmd_arbiter_if.sv
// Requester-side write handshakes plus the shared command bus outputs.
// slave = the arbiter, master = the requesters/consumers around it.
interface cmd_arbiter_if;
    logic       req_vjtag;
    logic [7:0] addr_vjtag;
    logic [7:0] data_vjtag;
    logic       ack_vjtag;
    logic       req_export;
    logic [7:0] addr_export;
    logic [7:0] data_export;
    logic       ack_export;
    logic [7:0] addr;
    logic [7:0] data_out;
    logic       sw_out;
    logic       reset_out;
    logic       busy;

    modport slave (
        input  req_vjtag, addr_vjtag, data_vjtag,
        input  req_export, addr_export, data_export,
        output ack_vjtag, ack_export,
        output addr, data_out, sw_out, reset_out, busy
    );

    modport master (
        output req_vjtag, addr_vjtag, data_vjtag,
        output req_export, addr_export, data_export,
        input  ack_vjtag, ack_export,
        input  addr, data_out, sw_out, reset_out, busy
    );
endinterface

// File: rtl/cmd_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, combinational from req.
// The last-grant register only moves on update; a tie goes to the other side.
module rr_arb2
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_id,
    output logic [1:0] gnt
);

    logic last;

    // Reset to export so that the first tie goes to vjtag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= GNT_EXPORT;
        end else if (update) begin
            last <= upd_id;
        end
    end

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = '0;
            if (last == GNT_VJTAG) begin
                gnt[GNT_EXPORT] = 1'b1;
            end else begin
                gnt[GNT_VJTAG] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Serialises vjtag/export writes onto the command bus: addr for HOLD cycles, strobe for HOLD, one-cycle ack.
// Requests wait (req held) while busy; soft-reset command adds a RST_CYCLES reset_out pulse.
module cmd_arbiter
    import cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 200000000,
    parameter int unsigned HOLD       = CLK_FREQ / 2500000,
    parameter int unsigned RST_CYCLES = CLK_FREQ / 1000
)(
    input  logic          clk,
    input  logic          reset,
    cmd_arbiter_if.slave  bus
);

    localparam int unsigned HOLD_C = (HOLD == 0) ? 1 : HOLD;
    localparam int unsigned RST_C  = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam logic [31:0] HOLD_LD = 32'(HOLD_C - 1);
    localparam logic [31:0] RST_LD  = 32'(RST_C - 1);

    state_t      state, nxt_state;
    logic [31:0] cnt, cnt_nxt;
    cmd_t        cmd_q, req_cmd;
    logic        gnt_id;
    logic [7:0]  addr_q, data_q;
    logic [1:0]  gnt;
    logic        take, load_data, clr_addr, arb_upd;
    logic        sw, ack_v, ack_e, rst_o, busy_o;

    rr_arb2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({bus.req_export, bus.req_vjtag}),
        .update (arb_upd),
        .upd_id (gnt_id),
        .gnt    (gnt)
    );

    always_comb begin
        req_cmd = gnt[GNT_EXPORT] ? cmd_t'{addr: bus.addr_export, data: bus.data_export}
                                  : cmd_t'{addr: bus.addr_vjtag,  data: bus.data_vjtag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        cnt_nxt   = (cnt != 32'd0) ? cnt - 32'd1 : cnt;
        take      = 1'b0;
        load_data = 1'b0;
        clr_addr  = 1'b0;
        arb_upd   = 1'b0;
        sw        = 1'b0;
        ack_v     = 1'b0;
        ack_e     = 1'b0;
        rst_o     = 1'b0;
        busy_o    = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (|gnt) begin
                    take      = 1'b1;
                    cnt_nxt   = HOLD_LD;
                    nxt_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cnt == 32'd0) begin
                    load_data = 1'b1;
                    cnt_nxt   = HOLD_LD;
                    nxt_state = ST_STROBE;
                end
            end
            ST_STROBE: begin
                sw = 1'b1;
                if (cnt == 32'd0) begin
                    nxt_state = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_v   = (gnt_id == GNT_VJTAG);
                ack_e   = (gnt_id == GNT_EXPORT);
                arb_upd = 1'b1;
                if (is_softrst(cmd_q)) begin
                    clr_addr  = 1'b1;
                    cnt_nxt   = RST_LD;
                    nxt_state = ST_SOFTRST;
                end else begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_SOFTRST: begin
                rst_o = 1'b1;
                if (cnt == 32'd0) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: begin
                busy_o    = 1'b0;
                cnt_nxt   = '0;
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: command captured at grant so later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            cmd_q  <= '0;
            gnt_id <= GNT_VJTAG;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (take) begin
                cmd_q  <= req_cmd;
                gnt_id <= gnt[GNT_EXPORT];
                addr_q <= req_cmd.addr;
            end
            if (load_data) begin
                data_q <= cmd_q.data;
            end
            if (clr_addr) begin
                addr_q <= '0;
            end
        end
    end

    assign bus.addr      = addr_q;
    assign bus.data_out  = data_q;
    assign bus.sw_out    = sw;
    assign bus.ack_vjtag = ack_v;
    assign bus.ack_export = ack_e;
    assign bus.reset_out = rst_o;
    assign bus.busy      = busy_o;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: scoreboarded requesters on a HOLD=4 instance,
// plus a directed HOLD=0 instance.
module tb_cmd_arbiter;
    import cmd_pkg::*;

    localparam int HOLD = 4;
    localparam int RSTC = 10;

    typedef struct {
        logic       who;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         drop;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_arbiter_if bus0();
    cmd_arbiter_if bus1();

    cmd_arbiter #(.CLK_FREQ(200000000), .HOLD(HOLD), .RST_CYCLES(RSTC)) u_dut (
        .clk(clk), .reset(rst_n), .bus(bus0.slave));

    cmd_arbiter #(.CLK_FREQ(200000000), .HOLD(0), .RST_CYCLES(RSTC)) u_h0 (
        .clk(clk), .reset(rst_n), .bus(bus1.slave));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    exp_t exp_q[$];
    req_t vq[$];
    req_t eq[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // vjtag requester: holds req until ack (optionally drops it early)
    initial begin : vjtag_drv
        req_t r;
        logic got;
        bus0.req_vjtag = 1'b0; bus0.addr_vjtag = '0; bus0.data_vjtag = '0;
        forever begin
            while (vq.size() == 0) @(negedge clk);
            r = vq[0];
            got = 1'b0;
            @(negedge clk);
            bus0.addr_vjtag = r.a; bus0.data_vjtag = r.d; bus0.req_vjtag = 1'b1;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (r.drop != 0 && c + 1 == r.drop) bus0.req_vjtag = 1'b0;
                if (bus0.ack_vjtag) got = 1'b1;
            end
            bus0.req_vjtag = 1'b0;
            chk("vjtag_ack_seen", got, 1);
            void'(vq.pop_front());
        end
    end

    initial begin : export_drv
        req_t r;
        logic got;
        bus0.req_export = 1'b0; bus0.addr_export = '0; bus0.data_export = '0;
        forever begin
            while (eq.size() == 0) @(negedge clk);
            r = eq[0];
            got = 1'b0;
            @(negedge clk);
            bus0.addr_export = r.a; bus0.data_export = r.d; bus0.req_export = 1'b1;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (r.drop != 0 && c + 1 == r.drop) bus0.req_export = 1'b0;
                if (bus0.ack_export) got = 1'b1;
            end
            bus0.req_export = 1'b0;
            chk("export_ack_seen", got, 1);
            void'(eq.pop_front());
        end
    end

    // Monitor: pops the scoreboard on each strobe, checks ack ownership/timing and soft-reset pulse
    logic sw_prev = 1'b0, ack_prev = 1'b0, rst_prev = 1'b0, cur_vld = 1'b0;
    exp_t cur;
    int sw_len = 0, rst_len = 0;
    int rise_q[$];
    int last_rise = 0, last_ack_cyc = 0, rst_fall_cyc = 0, rst_gap = 0;
    int ack_v_n = 0, ack_e_n = 0;

    initial begin : mon
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sw_prev = 1'b0; ack_prev = 1'b0; rst_prev = 1'b0;
                cur_vld = 1'b0; sw_len = 0; rst_len = 0;
                continue;
            end
            if (bus0.sw_out && !sw_prev) begin
                rise_q.push_back(cyc);
                last_rise = cyc;
                sw_len = 1;
                chk("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    cur_vld = 1'b1;
                    chk("strobe_addr", bus0.addr, cur.a);
                    chk("strobe_data", bus0.data_out, cur.d);
                end
            end else if (bus0.sw_out) begin
                sw_len++;
            end
            if (!bus0.sw_out && sw_prev) chk("strobe_len", sw_len, HOLD);
            if (bus0.ack_vjtag || bus0.ack_export) begin
                chk("ack_exclusive", bus0.ack_vjtag & bus0.ack_export, 0);
                chk("ack_single_cycle", ack_prev, 0);
                chk("ack_has_txn", cur_vld, 1);
                if (cur_vld) chk("ack_owner", bus0.ack_export, cur.who);
                chk("ack_delay", cyc - last_rise, HOLD);
                cur_vld = 1'b0;
                last_ack_cyc = cyc;
                if (bus0.ack_vjtag) ack_v_n++;
                if (bus0.ack_export) ack_e_n++;
            end
            if (bus0.reset_out) begin
                if (!rst_prev) rst_gap = cyc - last_ack_cyc;
                rst_len++;
                chk("softrst_addr", bus0.addr, 0);
                chk("softrst_no_strobe", bus0.sw_out, 0);
            end else if (rst_prev) begin
                chk("softrst_len", rst_len, RSTC);
                rst_len = 0;
                rst_fall_cyc = cyc;
            end
            sw_prev = bus0.sw_out;
            ack_prev = bus0.ack_vjtag | bus0.ack_export;
            rst_prev = bus0.reset_out;
        end
    end

    task automatic push(input logic who, input logic [7:0] a, input logic [7:0] d, input int drop);
        req_t r;
        r.a = a; r.d = d; r.drop = drop;
        exp_q.push_back('{who: who, a: a, d: d});
        if (who == GNT_EXPORT) eq.push_back(r);
        else vq.push_back(r);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || vq.size() != 0 || eq.size() != 0 || cur_vld || bus0.busy)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 500, 1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int v0, e0, r0, n;
        bus1.req_vjtag = 1'b0; bus1.addr_vjtag = '0; bus1.data_vjtag = '0;
        bus1.req_export = 1'b0; bus1.addr_export = '0; bus1.data_export = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", bus0.addr, 0);
        chk("rst_data", bus0.data_out, 0);
        chk("rst_sw", bus0.sw_out, 0);
        chk("rst_reset_out", bus0.reset_out, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_acks", {bus0.ack_vjtag, bus0.ack_export}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single vjtag write
        v0 = ack_v_n; e0 = ack_e_n;
        @(posedge clk); #1;
        push(GNT_VJTAG, 8'h10, 8'hA5, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_addr_pre_grant", bus0.addr, 0);
        @(negedge clk);
        chk("t1_addr_after_grant", bus0.addr, 8'h10);
        chk("t1_busy", bus0.busy, 1);
        chk("t1_sw_in_addr", bus0.sw_out, 0);
        wait_done("t1_done");
        chk("t1_ack_v", ack_v_n - v0, 1);
        chk("t1_ack_e", ack_e_n - e0, 0);

        // Export request dropped during ADDR still completes
        v0 = ack_v_n; e0 = ack_e_n;
        @(posedge clk); #1;
        push(GNT_EXPORT, 8'h40, 8'h77, 2);
        wait_done("t5_done");
        chk("t5_ack_e", ack_e_n - e0, 1);
        chk("t5_ack_v", ack_v_n - v0, 0);

        // Both held: alternating grants, 10 cycles apart
        r0 = rise_q.size();
        @(posedge clk); #1;
        push(GNT_VJTAG, 8'h20, 8'h11, 0);
        push(GNT_EXPORT, 8'h30, 8'h22, 0);
        push(GNT_VJTAG, 8'h20, 8'h11, 0);
        push(GNT_EXPORT, 8'h30, 8'h22, 0);
        wait_done("t2_done");
        chk("t2_nstrobe", rise_q.size() - r0, 4);
        for (int i = 1; i < 4; i++)
            if (r0 + i < rise_q.size()) chk("t2_spacing", rise_q[r0 + i] - rise_q[r0 + i - 1], 2 * HOLD + 2);

        // Soft reset from export, vjtag request raised during SOFTRST
        v0 = ack_v_n; e0 = ack_e_n;
        @(posedge clk); #1;
        push(GNT_EXPORT, SOFTRST_ADDR, SOFTRST_DATA, 0);
        n = 0;
        while (!bus0.reset_out && n < 100) begin @(negedge clk); n++; end
        chk("t3_softrst_seen", bus0.reset_out, 1);
        @(posedge clk); #1;
        push(GNT_VJTAG, 8'h33, 8'h44, 0);
        wait_done("t3_done");
        chk("t3_rst_after_ack", rst_gap, 1);
        chk("t3_grant_after_rst", last_rise - rst_fall_cyc, HOLD + 1);
        chk("t3_ack_e", ack_e_n - e0, 1);
        chk("t3_ack_v", ack_v_n - v0, 1);

        // Async reset mid-STROBE: export abandoned, vjtag wins after release
        v0 = ack_v_n; e0 = ack_e_n;
        @(posedge clk); #1;
        push(GNT_EXPORT, 8'h50, 8'h51, 0);
        push(GNT_VJTAG, 8'h60, 8'h61, 0);
        exp_q.push_back('{who: GNT_EXPORT, a: 8'h50, d: 8'h51});
        n = 0;
        while (!bus0.sw_out && n < 100) begin @(negedge clk); n++; end
        chk("t4_strobe_seen", bus0.sw_out, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_sw_in_reset", bus0.sw_out, 0);
        chk("t4_addr_in_reset", bus0.addr, 0);
        chk("t4_busy_in_reset", bus0.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done("t4_done");
        chk("t4_ack_v", ack_v_n - v0, 1);
        chk("t4_ack_e", ack_e_n - e0, 1);
        chk("sb_empty", exp_q.size(), 0);

        // HOLD=0 instance behaves as HOLD=1
        @(negedge clk);
        chk("h0_idle_busy", bus1.busy, 0);
        bus1.addr_vjtag = 8'h55; bus1.data_vjtag = 8'h66; bus1.req_vjtag = 1'b1;
        @(negedge clk);
        chk("h0_addr", bus1.addr, 8'h55);
        chk("h0_addr_phase_sw", bus1.sw_out, 0);
        @(negedge clk);
        chk("h0_strobe", bus1.sw_out, 1);
        chk("h0_data", bus1.data_out, 8'h66);
        @(negedge clk);
        chk("h0_sw_after", bus1.sw_out, 0);
        chk("h0_ack_v", bus1.ack_vjtag, 1);
        chk("h0_ack_e", bus1.ack_export, 0);
        bus1.req_vjtag = 1'b0;
        @(negedge clk);
        chk("h0_ack_done", bus1.ack_vjtag, 0);
        chk("h0_idle_again", bus1.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Shares the 8-bit command bus (addr, data_out, sw_out) between two write requesters: the vjtag side and the export side.
- Serialises their addr+data write transactions with round-robin fairness, holds the address and then the write strobe for the configured hold time, and acknowledges each transaction.
- Detects the soft-reset command (addr 0x01, data 0x02) and issues a timed reset_out pulse.
- Sits between the vjtag/export front-ends and the register/counter blocks that consume the command bus.

Parameters:
- CLK_FREQ, 200000000, system clock frequency in Hz.
- HOLD, CLK_FREQ/2500000 (=80), cycles that addr is held before the strobe, and cycles that sw_out is held high. A value of 0 is treated as 1.
- RST_CYCLES, CLK_FREQ/1000 (=200000), cycles that reset_out is held high after a soft-reset command. A value of 0 is treated as 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_vjtag  in  1  vjtag write request; held high until ack_vjtag.
- addr_vjtag  in  8  vjtag target address; valid while req_vjtag is high.
- data_vjtag  in  8  vjtag write data; valid while req_vjtag is high.
- ack_vjtag  out  1  one-cycle completion pulse to vjtag.
- req_export  in  1  export write request; held high until ack_export.
- addr_export  in  8  export target address.
- data_export  in  8  export write data.
- ack_export  out  1  one-cycle completion pulse to export.
- addr  out  8  command bus address.
- data_out  out  8  command bus data.
- sw_out  out  1  command bus write strobe.
- reset_out  out  1  soft-reset pulse to downstream blocks.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0: addr, data_out, sw_out, reset_out, both acks, busy.
  - State goes to IDLE; the hold counter is cleared.
  - The round-robin pointer is set so that vjtag wins the first tie.
  - A transaction in progress is abandoned and never acknowledged.
- States: IDLE, ADDR, STROBE, ACK, SOFTRST. Register encoding is safe; any illegal state goes to IDLE.
- IDLE:
  - Grant rules, sampled at the clock edge:
    - Only one request high: grant it.
    - Both high: grant the requester that was not granted last.
    - Neither high: stay in IDLE.
  - On grant, latch the granted requester's addr/data into internal registers and the grant id, load cnt=HOLD-1, and go to ADDR.
  - Later changes to the requester's inputs do not affect the transaction in progress.
- ADDR:
  - addr is driven with the latched address from the first cycle after the grant; sw_out=0.
  - Stays for exactly HOLD cycles (cnt counts down to 0), then loads cnt=HOLD-1 and goes to STROBE.
- STROBE:
  - sw_out=1 and data_out=latched data for exactly HOLD cycles; addr is unchanged.
  - data_out is valid on the first cycle that sw_out is high.
- ACK:
  - One cycle. sw_out=0 and the ack of the granted requester is 1.
  - The round-robin pointer is updated here.
  - If the latched command is addr==0x01 and data==0x02: load cnt=RST_CYCLES-1 and go to SOFTRST. Otherwise go to IDLE.
  - The requester deasserts req on the edge that samples ack, so IDLE never sees a stale request.
- SOFTRST:
  - reset_out=1 for exactly RST_CYCLES cycles, and addr is forced to 0x00.
  - No grants are made; pending requests wait.
  - On exit, reset_out=0 and the block goes to IDLE.
- data_out holds its last value outside STROBE; it is not cleared.
- Throughput: a normal transaction occupies 2*HOLD+1 cycles after the grant edge, plus 1 IDLE cycle, before the next grant.
- Counter: 32-bit unsigned. Decrement only when cnt>0; the transition happens when cnt==0.
- An ack is asserted for exactly one cycle and only for the granted requester. The two acks are never high together.
- A request that drops mid-transaction is ignored; the transaction completes and is still acknowledged.

Decomposition:
- Package cmd_pkg holds:
  - the state encoding constants;
  - the SOFTRST_ADDR=8'h01 and SOFTRST_DATA=8'h02 constants;
  - the grant-id constants GNT_VJTAG=0 and GNT_EXPORT=1.
- One sub-module, rr_arb2: a two-input round-robin arbiter with a last-grant register, an update strobe and a one-hot grant output.
- The hold counter and FSM stay in cmd_arbiter.

Test Plan:
All scenarios use HOLD=4 and RST_CYCLES=10.
- Single vjtag write: req_vjtag with addr 0x10, data 0xA5 → addr=0x10 from the cycle after the grant; sw_out high for 4 cycles starting 4 cycles later with data_out=0xA5; ack_vjtag pulses once at grant+9; ack_export stays 0.
- Simultaneous requests held (vjtag 0x20/0x11, export 0x30/0x22) → grant order is vjtag, export, vjtag, export; each transaction is 10 cycles apart; strobes never overlap.
- Soft reset from export (addr 0x01, data 0x02) → normal strobe, then ack_export; reset_out is high for 10 cycles with addr=0x00; a vjtag request raised during SOFTRST is granted only afterwards.
- Async reset asserted in the middle of STROBE → sw_out, addr and busy are 0 within the same cycle and no ack is issued; after release, a pending vjtag request is granted first.
- Request dropped during ADDR (export 0x40/0x77) → the transaction still completes: sw_out for 4 cycles with data 0x77, ack_export pulses once.
- HOLD=0 override → behaves exactly as HOLD=1: addr 1 cycle, sw_out 1 cycle, ack on the next cycle.
